button_encoder_4x2: RTL and testbench

BUTTON_ENCODER_4X2 -- requirements
Module: button_encoder_4x2

---
 rtl/button_encoder_4x2_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 56 +++++
 rtl/button_encoder_4x2.sv | 91 +++++++++
 tb/tb_button_encoder_4x2.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/button_encoder_4x2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_encoder_4x2_pkg
// Purpose  : Shared FSM encoding, default debounce length and encode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package button_encoder_4x2_pkg;

    localparam int c_DEFAULT_DEBOUNCE_CYCLES = 100000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bit 0 has the highest priority.
    function automatic logic [1:0] lowestIndex(input logic [3:0] vec);
        logic [1:0] idx;
        if (vec[0])      idx = 2'd0;
        else if (vec[1]) idx = 2'd1;
        else if (vec[2]) idx = 2'd2;
        else             idx = 2'd3;
        return idx;
    endfunction

    function automatic logic isMulti(input logic [3:0] vec);
        return ((vec & (vec - 4'd1)) != 4'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchronizer followed by a stable-vector debouncer.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
    import button_encoder_4x2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [3:0] i_btn,
    output logic [3:0] deb
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]         r_s1;
    logic [3:0]         r_s2;
    logic [3:0]         r_cand;
    logic [3:0]         r_deb;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_s1 <= 4'b0000;
            r_s2 <= 4'b0000;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

    // Any change of the synchronized vector restarts the stability window.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cand <= 4'b0000;
            r_cnt  <= '0;
            r_deb  <= 4'b0000;
        end else if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_deb  <= r_cand;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign deb = r_deb;

endmodule
`default_nettype wire

// File: rtl/button_encoder_4x2.sv
`default_nettype none
// ============================================================================
// Module   : button_encoder_4x2
// Purpose  : Debounced 4-button panel encoder with press pulse and hold flags.
// Revision : 1.0 - initial release
// ============================================================================
module button_encoder_4x2
    import button_encoder_4x2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [3:0] i_btn,
    output logic [1:0] o_code,
    output logic       o_valid,
    output logic       o_pressed,
    output logic       o_multi
);

    logic [3:0] w_deb;
    state_t     r_state;
    state_t     w_nextState;
    logic       w_press;
    logic [1:0] r_code;
    logic       r_valid;
    logic       r_pressed;
    logic       r_multi;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_btn    (i_btn),
        .deb      (w_deb)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_press     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_deb != 4'b0000) begin
                    w_nextState = HOLD;
                    w_press     = 1'b1;
                end
            end
            HOLD: begin
                if (w_deb == 4'b0000) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Code is only captured on a fresh press, so roll-over keeps the first key.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_code    <= 2'd0;
            r_valid   <= 1'b0;
            r_pressed <= 1'b0;
            r_multi   <= 1'b0;
        end else begin
            r_valid   <= w_press;
            r_pressed <= (w_nextState == HOLD);
            r_multi   <= isMulti(w_deb);
            if (w_press) begin
                r_code <= lowestIndex(w_deb);
            end
        end
    end

    assign o_code    = r_code;
    assign o_valid   = r_valid;
    assign o_pressed = r_pressed;
    assign o_multi   = r_multi;

endmodule
`default_nettype wire

// File: tb/tb_button_encoder_4x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_encoder_4x2
// Purpose  : Directed and random bench for button_encoder_4x2 with a
//            sample-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_encoder_4x2;

    localparam int c_D = 4;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic [3:0] i_btn = 4'b0000;
    logic [1:0] o_code;
    logic       o_valid;
    logic       o_pressed;
    logic       o_multi;

    int errors = 0;
    int checks = 0;
    int validCount = 0;

    // A vector is accepted once D+1 consecutive samples (two edges old) agree.
    logic [3:0] smp[$];
    logic [3:0] mDebNow = 4'b0000;
    logic [3:0] mDebLast = 4'b0000;
    logic       mValid = 1'b0;
    logic [1:0] mCode = 2'd0;
    logic       mPressed = 1'b0;
    logic       mMulti = 1'b0;

    button_encoder_4x2 #(
        .DEBOUNCE_CYCLES(c_D)
    ) dut (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_btn    (i_btn),
        .o_code   (o_code),
        .o_valid  (o_valid),
        .o_pressed(o_pressed),
        .o_multi  (o_multi)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [1:0] firstSet(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[k]) return 2'(k);
        end
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelEdge(input logic [3:0] b, input logic rn);
        logic       allSame;
        logic [3:0] newDeb;
        if (!rn) begin
            smp.delete();
            for (int k = 0; k < c_D + 3; k++) smp.push_back(4'b0000);
            mDebNow  = 4'b0000;
            mDebLast = 4'b0000;
            mValid   = 1'b0;
            mCode    = 2'd0;
            mPressed = 1'b0;
            mMulti   = 1'b0;
        end else begin
            mValid   = (mDebNow != 4'b0000) && (mDebLast == 4'b0000);
            if (mValid) mCode = firstSet(mDebNow);
            mPressed = (mDebNow != 4'b0000);
            mMulti   = ($countones(mDebNow) > 1);
            smp.push_back(b);
            void'(smp.pop_front());
            allSame = 1'b1;
            for (int k = 1; k <= c_D; k++) begin
                if (smp[k] != smp[0]) allSame = 1'b0;
            end
            newDeb   = allSame ? smp[0] : mDebNow;
            mDebLast = mDebNow;
            mDebNow  = newDeb;
        end
    endtask

    task automatic step(input logic [3:0] b, input logic rn);
        i_btn     = b;
        i_reset_n = rn;
        @(posedge i_clk);
        modelEdge(b, rn);
        #1;
        chk("valid", {3'b000, o_valid}, {3'b000, mValid});
        chk("code", {2'b00, o_code}, {2'b00, mCode});
        chk("pressed", {3'b000, o_pressed}, {3'b000, mPressed});
        chk("multi", {3'b000, o_multi}, {3'b000, mMulti});
        chk("deb", dut.u_debounce.deb, mDebNow);
        if (o_valid) validCount++;
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        for (int k = 0; k < n; k++) step(b, 1'b1);
    endtask

    initial begin
        // Reset state
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        chk("rst_outputs", {o_code, o_valid, o_pressed}, 4'b0000);
        hold(4'b0000, 4);

        // Clean press of button 2: pulse after edge e7
        validCount = 0;
        hold(4'b0100, 7);
        chk("clean_before_e7", {3'b000, o_valid}, 4'd0);
        hold(4'b0100, 1);
        chk("clean_valid_e7", {3'b000, o_valid}, 4'd1);
        chk("clean_code", {2'b00, o_code}, 4'd2);
        chk("clean_pressed", {3'b000, o_pressed}, 4'd1);
        hold(4'b0100, 5);
        hold(4'b0000, 8);
        chk("clean_released", {3'b000, o_pressed}, 4'd0);
        chk("clean_pulses", 4'(validCount), 4'd1);

        // Bounce then hold button 0
        validCount = 0;
        for (int p = 0; p < 10; p++) hold((p % 2 == 0) ? 4'b0001 : 4'b0000, 2);
        hold(4'b0001, 12);
        chk("bounce_pulses", 4'(validCount), 4'd1);
        chk("bounce_code", {2'b00, o_code}, 4'd0);
        hold(4'b0000, 10);

        // Simultaneous 1010
        validCount = 0;
        hold(4'b1010, 10);
        chk("simul_code", {2'b00, o_code}, 4'd1);
        chk("simul_multi", {3'b000, o_multi}, 4'd1);
        chk("simul_pulses", 4'(validCount), 4'd1);
        hold(4'b0000, 10);

        // Roll-over
        validCount = 0;
        hold(4'b0001, 10);
        hold(4'b1001, 10);
        chk("roll_pulses", 4'(validCount), 4'd1);
        chk("roll_code", {2'b00, o_code}, 4'd0);
        chk("roll_multi", {3'b000, o_multi}, 4'd1);
        hold(4'b0000, 10);
        hold(4'b1000, 10);
        chk("roll_code3", {2'b00, o_code}, 4'd3);
        chk("roll_pulses2", 4'(validCount), 4'd2);
        hold(4'b0000, 10);

        // Reset while holding button 1
        hold(4'b0010, 10);
        step(4'b0010, 1'b0);
        chk("midrst_outputs", {o_code, o_valid, o_pressed}, 4'b0000);
        chk("midrst_multi", {3'b000, o_multi}, 4'd0);
        validCount = 0;
        hold(4'b0010, 10);
        chk("midrst_pulses", 4'(validCount), 4'd1);
        chk("midrst_code", {2'b00, o_code}, 4'd1);
        hold(4'b0000, 10);

        // Short glitch
        validCount = 0;
        hold(4'b0100, 3);
        hold(4'b0000, 10);
        chk("glitch_pulses", 4'(validCount), 4'd0);
        chk("glitch_deb", dut.u_debounce.deb, 4'b0000);

        // Random segments with occasional resets
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                step(4'($urandom_range(0, 15)), 1'b0);
            end else begin
                hold(4'($urandom_range(0, 15)), int'($urandom_range(1, 9)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
